// File: rtl/seven_segment_pkg.sv
// Shared types and the hex-to-segment glyph table for the scanned display.
// Segment vectors are packed {g,f,e,d,c,b,a}, 1 = lit.
package seven_segment_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_TABLE [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f,
    7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c,
    7'h39, 7'h5e, 7'h79, 7'h71
  };

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational nibble-to-glyph lookup.
// Anything that does not match a table entry decodes to all segments off.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = '0;
    for (int i = 0; i < 16; i++) begin
      if (nib == 4'(i)) seg = SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/seven_segment.sv
// Four-digit time-multiplexed seven-segment scanner with registered outputs.
// Define SEVEN_SEGMENT_BLANK_EN to suppress leading zeros on digits 3..1.
module seven_segment
  import seven_segment_pkg::*;
#(
  parameter int CLK_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd [3:0],
  output logic       segA,
  output logic       segB,
  output logic       segC,
  output logic       segD,
  output logic       segE,
  output logic       segF,
  output logic       segG,
  output logic [3:0] dsen
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          blank;
  seg_t          glyph;
  seg_t          seg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == LAST) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign nib = bcd[idx];

`ifdef SEVEN_SEGMENT_BLANK_EN
  always_comb begin
    blank = 1'b0;
    unique case (1'b1)
      idx == 2'd3: blank = (bcd[3] == 4'd0);
      idx == 2'd2: blank = (bcd[3] == 4'd0) &&
                           (bcd[2] == 4'd0);
      idx == 2'd1: blank = (bcd[3] == 4'd0) &&
                           (bcd[2] == 4'd0) &&
                           (bcd[1] == 4'd0);
      default:     blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  seven_segment_decoder u_dec (
    .nib (nib),
    .seg (glyph)
  );

  // Glyph and digit enable share one edge so no digit shows another's pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dsen  <= '0;
    end else begin
      seg_q <= blank ? '0 : glyph;
      dsen  <= 4'b0001 << idx;
    end
  end

  assign segA = seg_q[0];
  assign segB = seg_q[1];
  assign segC = seg_q[2];
  assign segD = seg_q[3];
  assign segE = seg_q[4];
  assign segF = seg_q[5];
  assign segG = seg_q[6];

endmodule

// File: tb/tb_seven_segment.sv
// Directed bench for the seven-segment scanner, with a cycle-count display model.
// Runs with CLK_DIV=4; honours SEVEN_SEGMENT_BLANK_EN if defined.
module tb_seven_segment;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] bcd [3:0];
  logic       segA, segB, segC, segD, segE, segF, segG;
  logic [3:0] dsen;
  logic [6:0] seg;

  int checks;
  int errors;

  logic [6:0] glyph [16];
  int         n;
  logic [6:0] exp_seg;
  logic [3:0] exp_dsen;
  bit         model_on;

  seven_segment #(.CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bcd   (bcd),
    .segA  (segA),
    .segB  (segB),
    .segC  (segC),
    .segD  (segD),
    .segE  (segE),
    .segF  (segF),
    .segG  (segG),
    .dsen  (dsen)
  );

  assign seg = {segG, segF, segE, segD, segC, segB, segA};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    glyph = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
              7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  end

  function automatic bit is_blank(int d);
    bit b;
    b = 1'b0;
`ifdef SEVEN_SEGMENT_BLANK_EN
    if (d > 0) begin
      b = 1'b1;
      for (int k = d; k < 4; k++)
        if (bcd[k] != 4'd0) b = 1'b0;
    end
`endif
    return b;
  endfunction

  // Model: n-th edge after release shows digit ((n-1)/DIV) mod 4.
  always @(posedge clk) begin
    int d;
    if (!rst_n) begin
      n = 0;
      exp_seg = '0;
      exp_dsen = '0;
    end else begin
      n = n + 1;
      d = ((n - 1) / DIV) % 4;
      exp_dsen = 4'(1 << d);
      exp_seg = is_blank(d) ? 7'h00 : glyph[bcd[d]];
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic [6:0] es;
      logic [3:0] ed;
      es = rst_n ? exp_seg : 7'h00;
      ed = rst_n ? exp_dsen : 4'h0;
      checks++;
      if (seg !== es || dsen !== ed) begin
        errors++;
        $display("FAIL model t=%0t seg=%h dsen=%b expected seg=%h dsen=%b",
                 $time, seg, dsen, es, ed);
      end
    end
  end

  task automatic chk(string name, logic [6:0] s, logic [3:0] d,
                     logic [6:0] es, logic [3:0] ed);
    checks++;
    if (s !== es || d !== ed) begin
      errors++;
      $display("FAIL %s seg=%h dsen=%b expected seg=%h dsen=%b",
               name, s, d, es, ed);
    end
  endtask

  // Wait for the first cycle of digit d's dwell (after leaving it if present).
  task automatic wait_dig(int d);
    int t;
    t = 0;
    while (dsen == 4'(1 << d) && t < 40) begin
      @(negedge clk);
      t++;
    end
    while (dsen != 4'(1 << d) && t < 80) begin
      @(negedge clk);
      t++;
    end
    if (dsen != 4'(1 << d)) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting digit %0d dsen=%b", d, dsen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_on = 1'b0;
    rst_n = 1'b0;
    bcd[0] = 4'd7; bcd[1] = 4'd9; bcd[2] = 4'd4; bcd[3] = 4'd1;
    repeat (3) @(negedge clk);
    model_on = 1'b1;
    chk("reset_dark", seg, dsen, 7'h00, 4'b0000);

    bcd[0] = 4'd0; bcd[1] = 4'd1; bcd[2] = 4'd2; bcd[3] = 4'd3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_d0", seg, dsen, 7'h3f, 4'b0001);
    repeat (DIV - 1) @(negedge clk);
    chk("d0_held", seg, dsen, 7'h3f, 4'b0001);
    @(negedge clk);
    chk("scan_d1", seg, dsen, 7'h06, 4'b0010);
    repeat (DIV) @(negedge clk);
    chk("scan_d2", seg, dsen, 7'h5b, 4'b0100);
    repeat (DIV) @(negedge clk);
    chk("scan_d3", seg, dsen, 7'h4f, 4'b1000);
    repeat (DIV) @(negedge clk);
    chk("scan_wrap", seg, dsen, 7'h3f, 4'b0001);

    for (int v = 0; v < 16; v++) begin
      bcd[0] = 4'(v);
      wait_dig(0);
      if (v == 8) chk("dec_8", seg, dsen, 7'h7f, 4'b0001);
      if (v == 15) chk("dec_F", seg, dsen, 7'h71, 4'b0001);
      if (v == 11) chk("dec_b", seg, dsen, 7'h7c, 4'b0001);
    end

    bcd[0] = 4'd1;
    wait_dig(0);
    bcd[0] = 4'd8;
    chk("live_old", seg, dsen, 7'h06, 4'b0001);
    @(negedge clk);
    chk("live_new", seg, dsen, 7'h7f, 4'b0001);
    bcd[3] = 4'hf;
    wait_dig(3);
    chk("live_d3", seg, dsen, 7'h71, 4'b1000);

    wait_dig(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_dark", seg, dsen, 7'h00, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_d0", seg, dsen, 7'h7f, 4'b0001);

    bcd[0] = 4'd0; bcd[1] = 4'd5; bcd[2] = 4'd0; bcd[3] = 4'd0;
    wait_dig(3);
`ifdef SEVEN_SEGMENT_BLANK_EN
    chk("blank_d3", seg, dsen, 7'h00, 4'b1000);
    wait_dig(2);
    chk("blank_d2", seg, dsen, 7'h00, 4'b0100);
`else
    chk("noblank_d3", seg, dsen, 7'h3f, 4'b1000);
    wait_dig(2);
    chk("noblank_d2", seg, dsen, 7'h3f, 4'b0100);
`endif
    wait_dig(1);
    chk("blank_d1", seg, dsen, 7'h6d, 4'b0010);
    wait_dig(0);
    chk("blank_d0", seg, dsen, 7'h3f, 4'b0001);

    repeat (4) @(negedge clk);
    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment.md
Name: seven_segment

Overview:
- Time-multiplexed driver for a 4-digit common-anode/cathode-agnostic seven-segment display.
- Takes four 4-bit hex nibbles and scans them one digit at a time.
- Drives seven active-high segment lines (segA..segG) and a one-hot active-high digit enable (dsen).
- Sits between display-value logic (counters, measurement readout) and the board's display pins.

Parameters:
- CLK_DIV, 1024, clock cycles each digit stays enabled before advancing; legal range ≥1.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- bcd  input  4x4 (unpacked [3:0] of [3:0])  hex value per digit; bcd[0] is the rightmost digit
- segA  output  1  segment a, active-high
- segB  output  1  segment b, active-high
- segC  output  1  segment c, active-high
- segD  output  1  segment d, active-high
- segE  output  1  segment e, active-high
- segF  output  1  segment f, active-high
- segG  output  1  segment g, active-high
- dsen  output  4  digit enable, one-hot, active-high; dsen[i] selects bcd[i]

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Prescaler = 0 and digit index = 0.
  - All seg outputs = 0 and dsen = 4'b0000. Outputs stay dark while reset is held.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - On the wrap cycle, the digit index advances 0→1→2→3→0.
  - With CLK_DIV=1, the index advances every cycle.
- Output registers, updated every clock:
  - dsen <= 1 << index.
  - seg <= decode(bcd[index]).
  - Latency is one cycle from an index change or a bcd change to the outputs.
  - bcd is not latched; a change mid-dwell appears on the next clock.
- First cycle after reset release: dsen=0001 with digit 0 decoded. Each digit is enabled for exactly CLK_DIV consecutive cycles.
- dsen is always exactly one-hot out of reset. The segment pattern and dsen switch on the same edge, so there is no cross-digit ghosting by construction.
- Decode, {g,f,e,d,c,b,a}, 1 = lit:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- X/Z on bcd: no requirement beyond synthesizable full-case decode (default = all off).
- Reset asserted mid-scan: immediate dark outputs. Restart is from digit 0 with the prescaler cleared.

Optional Feature:
- Macro: SEVEN_SEGMENT_BLANK_EN.
- Defined: leading-zero blanking.
  - Digit 3 is blanked if bcd[3]==0.
  - Digit 2 is blanked if bcd[3]==0 and bcd[2]==0.
  - Digit 1 is blanked if bcd[3..1] are all 0.
  - Digit 0 is never blanked.
  - A blanked digit outputs all segments 0; dsen still scans normally.
- Undefined: every digit is always decoded; "0000" displays four zeros.

Decomposition:
- Package seven_segment_pkg:
  - NUM_DIGITS=4.
  - typedef seg_t (logic [6:0], bit order g..a).
  - The 16-entry hex-to-segment constant table.
- Sub-module seven_segment_decoder: purely combinational, 4-bit nibble → seg_t using the package table. Instantiated once on the muxed nibble.

Test Plan:
- Reset: hold rst_n=0 with arbitrary bcd → dsen=0000 and all segs=0. Release → next edge gives dsen=0001.
- Scan order (CLK_DIV=4): bcd={3,2,1,0} → dsen 0001,0010,0100,1000,0001, each held 4 cycles; segs match 0,1,2,3 patterns.
- Full decode: sweep bcd[0] through 0..F with dsen=0001 → each output equals the table (8 → 1111111, F → 1110001).
- Live update: set bcd[0]=8 mid-dwell, then bcd[3]=F → digit 0 shows 1111111 one cycle later; digit 3's slot shows 1110001.
- Async reset mid-scan at digit 2 → outputs dark immediately without a clock edge. After release, the scan restarts at dsen=0001.
- With SEVEN_SEGMENT_BLANK_EN, bcd={0,0,5,0} → digits 3 and 2 give segs 0000000, digit 1 gives 1101101, digit 0 gives 0111111. Without the macro, digits 3 and 2 give 0111111.
